fsk_symbol_scheduler: RTL and testbench

//   Buffers payload bytes and sequences them, one bit per symbol period, onto the
//   DDS rf_data select line. Emits a preamble per frame and returns the line to 0
//   (freq0 / OOK carrier-off) when idle. Sits between the byte source and the DDS core.

---
 rtl/fsk_symbol_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_fsk_symbol_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_symbol_scheduler.sv
// fsk_symbol_scheduler
//   Buffers payload bytes in a small FIFO and serialises them, one bit per
//   symbol period, onto the DDS rf_data select line. Every frame starts with
//   an alternating 1,0,... preamble, carries back-to-back payload bytes LSB
//   first, and ends with a single 0 tail symbol. The line idles at 0.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-low
//   sym_period   clocks per symbol (0 behaves as 1), latched at frame start
//   byte_data    payload byte
//   byte_valid   byte_data valid
//   byte_ready   FIFO can accept a byte (registered, = !full)
//   tx_sym       symbol bit towards DDS rf_data
//   tx_active    high while a frame (preamble/data/tail) is on the line
//   sym_strobe   one-cycle pulse on the first cycle of every symbol
//   fifo_level   bytes currently stored
//   dbg_state    current FSM state (IDLE=0, LEAD=1, DATA=2, TAIL=3)
//
// Byte handshake: a byte is taken on every rising clk edge where
//   byte_valid && byte_ready are both high; the source must hold byte_data
//   stable while byte_valid is high and ready is low. byte_ready does not
//   depend combinationally on byte_valid.
module fsk_symbol_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int PERIOD_W   = 16,
    parameter int LEAD_SYMS  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PERIOD_W-1:0]           sym_period,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    output logic                          tx_sym,
    output logic                          tx_active,
    output logic                          sym_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    // Symbol index must cover both the preamble and the 8 data bits.
    localparam int IDX_W = ($clog2(LEAD_SYMS) > 3) ? $clog2(LEAD_SYMS) : 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEAD = 2'd1,
        S_DATA = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [IDX_W-1:0]    sym_idx_q, sym_idx_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                tx_sym_q, tx_sym_d;
    logic                tx_active_q, tx_active_d;
    logic                strobe_q, strobe_d;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                byte_ready_q, byte_ready_d;

    logic                push;
    logic                pop;
    logic                boundary;
    logic                fifo_has_data;
    logic [7:0]          head;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        sym_idx_d    = sym_idx_q;
        shreg_d      = shreg_q;
        tx_sym_d     = tx_sym_q;
        tx_active_d  = tx_active_q;
        strobe_d     = 1'b0;
        pop          = 1'b0;
        push         = byte_valid && byte_ready_q;
        // Decisions use the registered level, so a byte pushed this cycle
        // is only visible to the FSM on the next cycle.
        fifo_has_data = (level_q != '0);
        head          = mem_q[rd_ptr_q];
        boundary      = (cnt_q == period_q - PERIOD_W'(1));

        if (state_q != S_IDLE) begin
            cnt_d = boundary ? '0 : cnt_q + PERIOD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_sym_d    = 1'b0;
                tx_active_d = 1'b0;
                cnt_d       = '0;
                if (fifo_has_data) begin
                    state_d     = S_LEAD;
                    period_d    = (sym_period == '0) ? PERIOD_W'(1) : sym_period;
                    sym_idx_d   = '0;
                    tx_sym_d    = 1'b1;
                    tx_active_d = 1'b1;
                    strobe_d    = 1'b1;
                end
            end
            S_LEAD: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (sym_idx_q == IDX_W'(LEAD_SYMS - 1)) begin
                        // FIFO cannot be empty here: the frame started
                        // because it held a byte and nothing popped since.
                        pop       = 1'b1;
                        shreg_d   = head;
                        tx_sym_d  = head[0];
                        sym_idx_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        sym_idx_d = sym_idx_q + IDX_W'(1);
                        tx_sym_d  = ~tx_sym_q;
                    end
                end
            end
            S_DATA: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (sym_idx_q == IDX_W'(7)) begin
                        sym_idx_d = '0;
                        if (fifo_has_data) begin
                            pop      = 1'b1;
                            shreg_d  = head;
                            tx_sym_d = head[0];
                        end else begin
                            state_d  = S_TAIL;
                            tx_sym_d = 1'b0;
                        end
                    end else begin
                        sym_idx_d = sym_idx_q + IDX_W'(1);
                        shreg_d   = shreg_q >> 1;
                        tx_sym_d  = shreg_q[1];
                    end
                end
            end
            S_TAIL: begin
                if (boundary) begin
                    state_d     = S_IDLE;
                    tx_sym_d    = 1'b0;
                    tx_active_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = byte_data;
        end
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        level_d      = level_q + LVL_W'(push) - LVL_W'(pop);
        byte_ready_d = (level_d != LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            period_q     <= PERIOD_W'(1);
            sym_idx_q    <= '0;
            shreg_q      <= '0;
            tx_sym_q     <= 1'b0;
            tx_active_q  <= 1'b0;
            strobe_q     <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            byte_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            sym_idx_q    <= sym_idx_d;
            shreg_q      <= shreg_d;
            tx_sym_q     <= tx_sym_d;
            tx_active_q  <= tx_active_d;
            strobe_q     <= strobe_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign tx_sym     = tx_sym_q;
    assign tx_active  = tx_active_q;
    assign sym_strobe = strobe_q;
    assign fifo_level = level_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fsk_symbol_scheduler.sv
module tb_fsk_symbol_scheduler;

    localparam int DEPTH = 8;
    localparam int LEAD  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sym_period;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        tx_sym;
    logic        tx_active;
    logic        sym_strobe;
    logic [3:0]  fifo_level;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fsk_symbol_scheduler #(
        .FIFO_DEPTH(DEPTH),
        .PERIOD_W  (16),
        .LEAD_SYMS (LEAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_period(sym_period),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx_sym    (tx_sym),
        .tx_active (tx_active),
        .sym_strobe(sym_strobe),
        .fifo_level(fifo_level),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a byte queue plus the list of symbols still owed in
    // the current frame. Time inside a symbol is an elapsed-cycle count.
    logic [7:0] m_bytes[$];
    bit         m_syms[$];
    bit         m_active;
    bit         m_tail;
    bit         m_ready;
    int         m_p;
    int         m_e;

    int         act_cnt;
    int         strb_cnt;
    logic [31:0] sym_log;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rn, input bit v, input logic [7:0] d, input logic [15:0] per);
        bit         push;
        logic [7:0] b;
        push = v && m_ready;
        if (!rn) begin
            m_bytes.delete();
            m_syms.delete();
            m_active = 0;
            m_tail   = 0;
            m_ready  = 1;
            m_e      = 0;
            return;
        end
        if (m_active) begin
            m_e++;
            if (m_e == m_p) begin
                m_e = 0;
                void'(m_syms.pop_front());
                if (m_syms.size() == 0) begin
                    if (m_tail) begin
                        m_active = 0;
                    end else if (m_bytes.size() > 0) begin
                        b = m_bytes.pop_front();
                        for (int i = 0; i < 8; i++) m_syms.push_back(b[i]);
                    end else begin
                        m_syms.push_back(1'b0);
                        m_tail = 1;
                    end
                end
            end
        end else if (m_bytes.size() > 0) begin
            m_active = 1;
            m_tail   = 0;
            m_e      = 0;
            m_p      = (per == 0) ? 1 : int'(per);
            m_syms.delete();
            for (int i = 0; i < LEAD; i++) m_syms.push_back((i % 2) == 0);
        end
        if (push) m_bytes.push_back(d);
        m_ready = (m_bytes.size() < DEPTH);
    endtask

    // One clock: model follows the edge, outputs are compared 1ns later.
    task automatic step();
        bit e_sym;
        @(posedge clk);
        model_edge(rst, byte_valid, byte_data, sym_period);
        #1;
        e_sym = m_active ? m_syms[0] : 1'b0;
        chk("tx_active", tx_active, m_active);
        chk("tx_sym", tx_sym, e_sym);
        chk("sym_strobe", sym_strobe, m_active && (m_e == 0));
        chk("fifo_level", fifo_level, m_bytes.size());
        chk("byte_ready", byte_ready, m_ready);
        if (tx_active) act_cnt++;
        if (sym_strobe) begin
            strb_cnt++;
            sym_log = {sym_log[30:0], tx_sym};
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_byte(input logic [7:0] d);
        byte_valid = 1'b1;
        byte_data  = d;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic clear_stats();
        act_cnt  = 0;
        strb_cnt = 0;
        sym_log  = '0;
    endtask

    initial begin
        int guard;
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        sym_period = 16'd4;
        m_ready    = 1;
        clear_stats();

        // Reset state
        steps(2);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", byte_ready, 1);
        rst = 1'b1;
        steps(3);

        // Single byte 0xA5 at P=4
        clear_stats();
        push_byte(8'hA5);
        steps(80);
        chk("t1_active_cycles", act_cnt, 68);
        chk("t1_strobes", strb_cnt, 17);
        chk("t1_symbols", sym_log[16:0], 32'b1_0101_0101_0100_1010 & 32'h1FFFF);

        // Two bytes back-to-back at P=2
        sym_period = 16'd2;
        clear_stats();
        push_byte(8'h01);
        push_byte(8'hFF);
        steps(60);
        chk("t2_active_cycles", act_cnt, 50);
        chk("t2_strobes", strb_cnt, 25);
        chk("t2_symbols", sym_log[24:0], {8'b1010_1010, 8'b1000_0000, 8'hFF, 1'b0});

        // Fill the FIFO at a very long period; the 9th byte is refused
        sym_period = 16'hFFFF;
        byte_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            byte_data = 8'(8'h10 + i);
            step();
        end
        byte_valid = 1'b0;
        step();
        chk("t3_full_level", fifo_level, 8);
        chk("t3_full_ready", byte_ready, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Fill again at P=3 and wait for the first pop to free a slot
        sym_period = 16'd3;
        byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            byte_data = 8'(8'h30 + i);
            step();
        end
        byte_valid = 1'b0;
        chk("t3b_full_ready", byte_ready, 0);
        guard = 0;
        while (!byte_ready && guard < 60) begin
            step();
            guard++;
        end
        chk("t3b_ready_returns", byte_ready, 1);
        chk("t3b_level_after_pop", fifo_level, 7);
        guard = 0;
        while ((tx_active || fifo_level != 0) && guard < 400) begin
            step();
            guard++;
        end
        chk("t3b_drained", tx_active, 0);
        steps(3);

        // sym_period=0 acts as P=1: strobe every active cycle
        sym_period = 16'd0;
        clear_stats();
        push_byte(8'h3C);
        steps(25);
        chk("t4_active_cycles", act_cnt, 17);
        chk("t4_strobes", strb_cnt, 17);

        // Period change mid-frame applies only to the next frame
        sym_period = 16'd4;
        clear_stats();
        push_byte(8'h5A);
        steps(20);
        sym_period = 16'd7;
        steps(70);
        chk("t5_frame1_cycles", act_cnt, 68);
        clear_stats();
        push_byte(8'hC3);
        steps(130);
        chk("t5_frame2_cycles", act_cnt, 119);

        // Reset in the middle of DATA
        sym_period = 16'd2;
        push_byte(8'h96);
        push_byte(8'h69);
        steps(26);
        chk("t6_in_data", dbg_state, 2);
        rst = 1'b0;
        step();
        chk("t6_tx_sym", tx_sym, 0);
        chk("t6_tx_active", tx_active, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_ready", byte_ready, 1);
        rst = 1'b1;
        clear_stats();
        steps(20);
        chk("t6_no_residual", act_cnt, 0);

        // Randomized traffic with random periods and occasional resets
        for (int c = 0; c < 2500; c++) begin
            if (c % 150 == 0) sym_period = 16'($urandom_range(0, 5));
            byte_valid = ($urandom_range(0, 99) < 25);
            byte_data  = 8'($urandom);
            rst        = ($urandom_range(0, 799) != 0);
            step();
        end
        rst        = 1'b1;
        byte_valid = 1'b0;
        guard = 0;
        while ((m_active || m_bytes.size() != 0) && guard < 800) begin
            step();
            guard++;
        end
        step();
        chk("rand_drained_active", tx_active, 0);
        chk("rand_drained_level", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
